// File: rtl/elastic_pipe_buffer.sv
// ---------------------------------------------------------------------------
// elastic_pipe_buffer
//   Small circular FIFO used as an elastic stage between two pipeline steps.
//   Words enter at the tail and leave from the head in strict order. Flush
//   squashes everything held (branch/jump). Out is forced to zero while
//   empty so an empty stage presents a NOP bubble downstream.
//
//   Parameters
//     WIDTH     bits per pipeline word
//     DEPTH     number of storage entries (1..16, any value)
//
//   Ports
//     Clk       single clock, rising edge
//     Rst       synchronous active-high reset (highest priority)
//     In        word offered by the upstream stage
//     In_valid  upstream word valid
//     In_ready  buffer can accept a word (Count < DEPTH), registered-only
//     Out       head word, zero when empty
//     Out_valid Out holds a valid word (Count > 0), registered-only
//     Out_ready downstream accepts Out this cycle
//     Flush     discard all held words (priority over push/pop)
//     Count     number of words currently held
// ---------------------------------------------------------------------------
module elastic_pipe_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [WIDTH-1:0]           In,
  input  logic                       In_valid,
  output logic                       In_ready,
  output logic [WIDTH-1:0]           Out,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  input  logic                       Flush,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  // Pointer width kept at least one bit so DEPTH=1 still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake flags come only from registered state, so neither ready nor
  // valid has a combinational path from the opposite side.
  assign In_ready  = (count_q < CW'(DEPTH));
  assign Out_valid = (count_q != '0);
  assign Count     = count_q;

  assign push = In_valid && In_ready;
  assign pop  = Out_valid && Out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: an empty buffer masks it on Out anyway.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk) begin
        if (!Rst && !Flush && push && (tail_q == PW'(gi))) begin
          mem_q[gi] <= In;
        end
      end
    end
  endgenerate

  // Head read; empty buffer shows the all-zero NOP bubble.
  always_comb begin
    Out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Out_valid && (head_q == PW'(i))) Out = mem_q[i];
    end
  end

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
module tb_elastic_pipe_buffer;

  localparam int W  = 16;
  localparam int DA = 2;
  localparam int DB = 3;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [W-1:0]  in_a, in_b;
  logic          iv_a, iv_b, or_a, or_b;
  logic          ir_a, ir_b, ov_a, ov_b;
  logic [W-1:0]  out_a, out_b;
  logic [1:0]    cnt_a;
  logic [1:0]    cnt_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference models: plain queues holding the words the buffer should hold.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] obs_b[$];
  logic         acc_b;
  logic         rec_b = 1'b0;

  always #5 clk = ~clk;

  elastic_pipe_buffer #(.WIDTH(W), .DEPTH(DA)) u_a (
    .Clk(clk), .Rst(rst), .In(in_a), .In_valid(iv_a), .In_ready(ir_a),
    .Out(out_a), .Out_valid(ov_a), .Out_ready(or_a), .Flush(flush), .Count(cnt_a)
  );

  elastic_pipe_buffer #(.WIDTH(W), .DEPTH(DB)) u_b (
    .Clk(clk), .Rst(rst), .In(in_b), .In_valid(iv_b), .In_ready(ir_b),
    .Out(out_b), .Out_valid(ov_b), .Out_ready(or_b), .Flush(flush), .Count(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_count", 64'(cnt_a), 64'(qa.size()));
    chk("a_out_valid", 64'(ov_a), 64'(qa.size() > 0));
    chk("a_in_ready", 64'(ir_a), 64'(qa.size() < DA));
    chk("a_out", 64'(out_a), (qa.size() > 0) ? 64'(qa[0]) : 64'd0);
    chk("b_count", 64'(cnt_b), 64'(qb.size()));
    chk("b_out_valid", 64'(ov_b), 64'(qb.size() > 0));
    chk("b_in_ready", 64'(ir_b), 64'(qb.size() < DB));
    chk("b_out", 64'(out_b), (qb.size() > 0) ? 64'(qb[0]) : 64'd0);
  endtask

  // One clock: decide pushes/pops from the model occupancy before the edge,
  // advance the queues, then check the DUTs one time unit after the edge.
  task automatic step();
    bit pa, pb, ka, kb;
    ka = iv_a && (qa.size() < DA);
    pa = (qa.size() > 0) && or_a;
    kb = iv_b && (qb.size() < DB);
    pb = (qb.size() > 0) && or_b;
    acc_b = kb && !rst && !flush;
    if (rec_b && ov_b && or_b && !rst && !flush) obs_b.push_back(out_b);
    @(posedge clk);
    if (rst || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pa) void'(qa.pop_front());
      if (ka) qa.push_back(in_a);
      if (pb) void'(qb.pop_front());
      if (kb) qb.push_back(in_b);
    end
    #1;
    check_all();
    $display("cyc rst=%0b fl=%0b | A in=%h v=%0b or=%0b -> out=%h ov=%0b ir=%0b cnt=%0d | B in=%h v=%0b or=%0b -> out=%h ov=%0b ir=%0b cnt=%0d",
             rst, flush, in_a, iv_a, or_a, out_a, ov_a, ir_a, cnt_a,
             in_b, iv_b, or_b, out_b, ov_b, ir_b, cnt_b);
  endtask

  task automatic push_a(input logic [W-1:0] d);
    in_a = d; iv_a = 1'b1; step(); iv_a = 1'b0;
  endtask

  initial begin
    int word;
    int maxcnt;
    int cyc;
    rst = 1'b1; flush = 1'b0;
    in_a = '0; in_b = '0; iv_a = 1'b0; iv_b = 1'b0;
    or_a = 1'b1; or_b = 1'b1;
    // Reset with inputs active: nothing may be accepted.
    iv_a = 1'b1; in_a = 16'hdead; iv_b = 1'b1; in_b = 16'hbeef;
    step(); step();
    chk("reset_count", 64'(cnt_a), 64'd0);
    chk("reset_in_ready", 64'(ir_a), 64'd1);
    rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0;
    step();

    // Basic flow, one-cycle latency.
    or_a = 1'b1;
    push_a(16'h00A1);
    chk("basic_out", 64'(out_a), 64'hA1);
    chk("basic_count", 64'(cnt_a), 64'd1);
    step();
    chk("basic_drain_out", 64'(out_a), 64'd0);
    chk("basic_drain_valid", 64'(ov_a), 64'd0);

    // Fill and backpressure.
    or_a = 1'b0;
    push_a(16'h0011);
    push_a(16'h0022);
    chk("fill_count", 64'(cnt_a), 64'd2);
    chk("fill_in_ready", 64'(ir_a), 64'd0);
    in_a = 16'h0033; iv_a = 1'b1;
    step();
    chk("full_hold_out", 64'(out_a), 64'h11);
    or_a = 1'b1;
    step();
    chk("bp_first_out", 64'(out_a), 64'h22);
    step();
    chk("bp_third_out", 64'(out_a), 64'h33);
    iv_a = 1'b0;
    step();
    // Empty with Out_ready high: no change.
    step();

    // Simultaneous push and pop.
    or_a = 1'b0;
    push_a(16'h0044);
    in_a = 16'h0055; iv_a = 1'b1; or_a = 1'b1;
    step();
    chk("simul_count", 64'(cnt_a), 64'd1);
    chk("simul_out", 64'(out_a), 64'h55);
    iv_a = 1'b0;
    step();

    // Flush priority over push and pop.
    or_a = 1'b0;
    push_a(16'h0066);
    push_a(16'h0067);
    flush = 1'b1; in_a = 16'h0068; iv_a = 1'b1; or_a = 1'b1;
    step();
    chk("flush_count", 64'(cnt_a), 64'd0);
    chk("flush_out", 64'(out_a), 64'd0);
    chk("flush_in_ready", 64'(ir_a), 64'd1);
    flush = 1'b0; iv_a = 1'b0;
    step(); step();

    // Reset mid-stream.
    or_a = 1'b0;
    push_a(16'h0071);
    push_a(16'h0072);
    rst = 1'b1;
    step();
    chk("midrst_valid", 64'(ov_a), 64'd0);
    rst = 1'b0;
    push_a(16'h0077);
    chk("midrst_push_out", 64'(out_a), 64'h77);
    or_a = 1'b1;
    step();

    // Random traffic on both instances, with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      iv_a  = 1'($urandom);
      iv_b  = 1'($urandom);
      or_a  = 1'($urandom);
      or_b  = 1'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b1; flush = 1'b0; iv_a = 1'b0; iv_b = 1'b0;
    step();
    rst = 1'b0;

    // Wrap on DEPTH=3: words 1..10 with random Out_ready.
    obs_b.delete();
    rec_b = 1'b1;
    word = 1;
    maxcnt = 0;
    cyc = 0;
    while (obs_b.size() < 10 && cyc < 200) begin
      in_b = W'(word);
      iv_b = (word <= 10);
      or_b = 1'($urandom);
      step();
      if (acc_b) word++;
      if (int'(cnt_b) > maxcnt) maxcnt = int'(cnt_b);
      cyc++;
    end
    rec_b = 1'b0;
    iv_b = 1'b0;
    chk("wrap_delivered", 64'(obs_b.size()), 64'd10);
    for (int i = 0; i < obs_b.size(); i++) chk("wrap_order", 64'(obs_b[i]), 64'(i + 1));
    chk("wrap_max_count_le3", 64'(maxcnt <= 3), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
